shiftreg_tap: RTL and testbench

//   Parametrised multi-stage shift register with runtime tap select. Generalises the fixed
//   3-stage 8-bit tap-select shift register to WIDTH bits and DEPTH stages, and adds:
//     - shift enable and synchronous clear;
//     - per-stage valid tracking, with an occupancy count and a full flag.

---
 rtl/shiftreg_tap.sv | 103 ++++++++++
 tb/tb_shiftreg_tap.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/shiftreg_tap.sv
// Parametrised WIDTH x DEPTH shift register with runtime tap select, per-stage valid and fill count.
// Define SHIFTREG_TAP_OREG_EN to register q/q_vld (adds one cycle of latency on every tap).
module shiftreg_tap #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    output logic [SELW-1:0]  fill_cnt,
    output logic             full
);

    logic [DEPTH:1][WIDTH-1:0] stg_q, stg_d;
    logic [DEPTH:1]            vld_q, vld_d;
    logic [SELW-1:0]           fill_q, fill_d;
    logic [WIDTH-1:0]          tap_data;
    logic                      tap_vld;

    always_comb begin
        stg_d  = stg_q;
        vld_d  = vld_q;
        fill_d = fill_q;
        if (clr) begin
            stg_d  = '0;
            vld_d  = '0;
            fill_d = '0;
        end else if (en) begin
            stg_d[1] = d;
            vld_d[1] = d_vld;
            for (int k = 2; k <= DEPTH; k++) begin
                stg_d[k] = stg_q[k-1];
                vld_d[k] = vld_q[k-1];
            end
            // Entry and exit cancel; the count never leaves 0..DEPTH because exit needs a valid last stage.
            fill_d = fill_q + SELW'(d_vld) - SELW'(vld_q[DEPTH]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q  <= '0;
            vld_q  <= '0;
            fill_q <= '0;
        end else begin
            stg_q  <= stg_d;
            vld_q  <= vld_d;
            fill_q <= fill_d;
        end
    end

    // Tap 0 is the live input; codes above DEPTH select nothing and read as zero.
    always_comb begin
        tap_data = '0;
        tap_vld  = 1'b0;
        if (sel == '0) begin
            tap_data = d;
            tap_vld  = d_vld;
        end
        for (int k = 1; k <= DEPTH; k++) begin
            if (sel == SELW'(k)) begin
                tap_data = stg_q[k];
                tap_vld  = vld_q[k];
            end
        end
    end

    assign fill_cnt = fill_q;
    assign full     = (fill_q == SELW'(DEPTH));

`ifdef SHIFTREG_TAP_OREG_EN
    logic [WIDTH-1:0] q_q;
    logic             q_vld_q;

    // Loads every cycle independent of en, so a tap change shows up one cycle later even while holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            q_vld_q <= 1'b0;
        end else if (clr) begin
            q_q     <= '0;
            q_vld_q <= 1'b0;
        end else begin
            q_q     <= tap_data;
            q_vld_q <= tap_vld;
        end
    end

    assign q     = q_q;
    assign q_vld = q_vld_q;
`else
    assign q     = tap_data;
    assign q_vld = tap_vld;
`endif

endmodule

// File: tb/tb_shiftreg_tap.sv
// Scoreboard bench for shiftreg_tap (WIDTH=8, DEPTH=3): stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_shiftreg_tap;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] d = 8'h00;
    logic       d_vld = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [7:0] q;
    logic       q_vld;
    logic [1:0] fill_cnt;
    logic       full;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic       qv;
        logic [1:0] fill;
        logic       full;
    } exp_t;

    exp_t sb[$];

    shiftreg_tap #(.WIDTH(8), .DEPTH(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .d        (d),
        .d_vld    (d_vld),
        .sel      (sel),
        .q        (q),
        .q_vld    (q_vld),
        .fill_cnt (fill_cnt),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".q"},     32'(q),        32'(e.q));
                chk({e.name, ".q_vld"}, 32'(q_vld),    32'(e.qv));
                chk({e.name, ".fill"},  32'(fill_cnt), 32'(e.fill));
                chk({e.name, ".full"},  32'(full),     32'(e.full));
            end
        end
    end

    task automatic step(input logic e_i, input logic c_i, input logic [7:0] d_i,
                        input logic dv_i, input logic [1:0] s_i);
        @(posedge clk);
        #1;
        en    = e_i;
        clr   = c_i;
        d     = d_i;
        d_vld = dv_i;
        sel   = s_i;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] eq, input logic eqv,
                              input logic [1:0] ef, input logic efull);
        exp_t e;
        e.name = nm;
        e.q    = eq;
        e.qv   = eqv;
        e.fill = ef;
        e.full = efull;
        sb.push_back(e);
    endtask

    initial begin
`ifdef SHIFTREG_TAP_OREG_EN
        step(0, 0, 8'h00, 0, 2'd0); expect_out("oreg_rst",   8'h00, 0, 2'd0, 0);
        step(1, 0, 8'h3C, 1, 2'd0); rst_n = 1'b1;
                                    expect_out("oreg_s0_c0", 8'h00, 0, 2'd0, 0);
        step(1, 0, 8'h00, 0, 2'd0); expect_out("oreg_s0_c1", 8'h3C, 1, 2'd1, 0);
        step(0, 0, 8'h00, 0, 2'd0); expect_out("oreg_s0_c2", 8'h00, 0, 2'd1, 0);
        step(0, 1, 8'h00, 0, 2'd0); expect_out("oreg_clr",   8'h00, 0, 2'd1, 0);
        step(1, 0, 8'h3C, 1, 2'd2); expect_out("oreg_s2_c0", 8'h00, 0, 2'd0, 0);
        step(1, 0, 8'h00, 0, 2'd2); expect_out("oreg_s2_c1", 8'h00, 0, 2'd1, 0);
        step(1, 0, 8'h00, 0, 2'd2); expect_out("oreg_s2_c2", 8'h00, 0, 2'd1, 0);
        step(0, 0, 8'h00, 0, 2'd2); expect_out("oreg_s2_c3", 8'h3C, 1, 2'd1, 0);
`else
        // Reset: tap 0 still passes d, deeper taps read zero.
        step(0, 0, 8'h77, 1, 2'd0); expect_out("rst_tap0",  8'h77, 1, 2'd0, 0);
        step(0, 0, 8'h77, 1, 2'd3); expect_out("rst_tap3",  8'h00, 0, 2'd0, 0);

        // Fill with 11,22,33,44 at sel=3.
        step(1, 0, 8'h11, 1, 2'd3); rst_n = 1'b1;
                                    expect_out("fill_c0",   8'h00, 0, 2'd0, 0);
        step(1, 0, 8'h22, 1, 2'd3); expect_out("fill_c1",   8'h00, 0, 2'd1, 0);
        step(1, 0, 8'h33, 1, 2'd3); expect_out("fill_c2",   8'h00, 0, 2'd2, 0);
        step(1, 0, 8'h44, 1, 2'd3); expect_out("fill_c3",   8'h11, 1, 2'd3, 1);

        // Push A1,B2,C3 so stage1=C3, stage3=A1.
        step(1, 0, 8'hA1, 1, 2'd3); expect_out("load_a1",   8'h22, 1, 2'd3, 1);
        step(1, 0, 8'hB2, 1, 2'd3); expect_out("load_b2",   8'h33, 1, 2'd3, 1);
        step(1, 0, 8'hC3, 1, 2'd3); expect_out("load_c3",   8'h44, 1, 2'd3, 1);

        // Hold and sweep taps.
        step(0, 0, 8'h5A, 1, 2'd0); expect_out("sweep_0",   8'h5A, 1, 2'd3, 1);
        step(0, 0, 8'h5A, 1, 2'd1); expect_out("sweep_1",   8'hC3, 1, 2'd3, 1);
        step(0, 0, 8'h5A, 1, 2'd2); expect_out("sweep_2",   8'hB2, 1, 2'd3, 1);
        step(0, 0, 8'h5A, 1, 2'd3); expect_out("sweep_3",   8'hA1, 1, 2'd3, 1);

        // Drain with invalid input.
        step(1, 0, 8'h00, 0, 2'd3); expect_out("drain_c0",  8'hA1, 1, 2'd3, 1);
        step(1, 0, 8'h00, 0, 2'd3); expect_out("drain_c1",  8'hB2, 1, 2'd2, 0);
        step(1, 0, 8'h00, 0, 2'd3); expect_out("drain_c2",  8'hC3, 1, 2'd1, 0);
        step(0, 0, 8'h00, 0, 2'd3); expect_out("drain_end", 8'h00, 0, 2'd0, 0);

        // Refill, then clr together with en.
        step(1, 0, 8'hD1, 1, 2'd3); expect_out("refill_c0", 8'h00, 0, 2'd0, 0);
        step(1, 0, 8'hD2, 1, 2'd3); expect_out("refill_c1", 8'h00, 0, 2'd1, 0);
        step(1, 0, 8'hD3, 1, 2'd3); expect_out("refill_c2", 8'h00, 0, 2'd2, 0);
        step(1, 1, 8'hEE, 1, 2'd3); expect_out("clr_pre",   8'hD1, 1, 2'd3, 1);
        step(0, 0, 8'hEE, 1, 2'd1); expect_out("clr_s1",    8'h00, 0, 2'd0, 0);
        step(0, 0, 8'hEE, 1, 2'd2); expect_out("clr_s2",    8'h00, 0, 2'd0, 0);
        step(0, 0, 8'hEE, 1, 2'd3); expect_out("clr_s3",    8'h00, 0, 2'd0, 0);

        // Partial fill, then async reset between edges.
        step(1, 0, 8'hF1, 1, 2'd1); expect_out("part_c0",   8'h00, 0, 2'd0, 0);
        step(1, 0, 8'hF2, 1, 2'd1); expect_out("part_c1",   8'hF1, 1, 2'd1, 0);
        step(0, 0, 8'h9C, 1, 2'd1); #1 rst_n = 1'b0;
                                    expect_out("arst_s1",   8'h00, 0, 2'd0, 0);
        step(0, 0, 8'h9C, 1, 2'd0); expect_out("arst_s0",   8'h9C, 1, 2'd0, 0);
        step(0, 0, 8'h9C, 1, 2'd2); rst_n = 1'b1;
                                    expect_out("arst_post", 8'h00, 0, 2'd0, 0);
`endif
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
